// File: rtl/fifo2uart_pkg.sv
// Shared types and constants for the FIFO-to-UART frame builder.
// State encoding, default frame delimiters and word/byte sizing helper.
package fifo2uart_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEAD,
    S_LEN,
    S_RD,
    S_WAIT,
    S_BYTE,
    S_CHK,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [7:0] DEF_HEAD = 8'hAA;
  localparam logic [7:0] DEF_TAIL = 8'h55;

  function automatic int bytes_of(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/fifo2uart_framer_uart_byte_out.sv
// Output byte register toward the UART transmitter.
// A loaded byte stays valid and unchanged until the transmitter takes it.
import fifo2uart_pkg::*;

module uart_byte_out (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       uart_txdr,
  output logic [7:0] uart_txd,
  output logic       uart_txdv,
  output logic       accepted
);

  assign accepted = uart_txdv & uart_txdr;

  // A reload in the accept cycle keeps the byte stream gap-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd  <= 8'h00;
      uart_txdv <= 1'b0;
    end else if (load) begin
      uart_txd  <= din;
      uart_txdv <= 1'b1;
    end else if (accepted) begin
      uart_txdv <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo2uart_framer.sv
// Drains data_len FIFO words into a framed UART byte stream:
// HEAD, length bytes, payload bytes MSB first, optional checksum, TAIL.
import fifo2uart_pkg::*;

module fifo2uart_framer #(
  parameter int         DATA_W = 8,
  parameter int         LEN_W  = 8,
  parameter logic [7:0] HEAD   = DEF_HEAD,
  parameter logic [7:0] TAIL   = DEF_TAIL,
  parameter bit         CHK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  input  logic [LEN_W-1:0]  data_len,
  output logic              fd,
  output logic              busy,
  output logic              fifo_rxen,
  input  logic [DATA_W-1:0] fifo_rxd,
  input  logic              fifo_empty,
  output logic [7:0]        uart_txd,
  output logic              uart_txdv,
  input  logic              uart_txdr
);

  localparam int         BYTES     = bytes_of(DATA_W);
  localparam int         LBYTES    = LEN_W / 8;
  localparam logic [7:0] LEN_LAST  = 8'(LBYTES - 1);
  localparam logic [7:0] WORD_LAST = 8'(BYTES - 1);

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_sh;
  logic [LEN_W-1:0]   wcnt;
  logic [DATA_W-1:0]  word_q;
  logic [7:0]         idx;
  logic [7:0]         chk;

  logic               load;
  logic [7:0]         din;
  logic               acc;
  logic [7:0]         sum_nx;
  logic [7:0]         fin_byte;
  logic [LEN_W-1:0]   len_nx;
  logic [DATA_W-1:0]  word_nx;
  logic [LEN_W-1:0]   wcnt_inc;
  logic               last_word;

  uart_byte_out u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .uart_txdr (uart_txdr),
    .uart_txd  (uart_txd),
    .uart_txdv (uart_txdv),
    .accepted  (acc)
  );

  assign sum_nx    = chk + uart_txd;
  assign fin_byte  = CHK_EN ? sum_nx : TAIL;
  assign len_nx    = len_sh << 8;
  assign word_nx   = word_q << 8;
  assign wcnt_inc  = wcnt + LEN_W'(1);
  assign last_word = (wcnt_inc == len_q);

  // The next byte is chosen in the cycle the current one is accepted,
  // so consecutive bytes go out back to back.
  always_comb begin
    load      = 1'b0;
    din       = 8'h00;
    fifo_rxen = 1'b0;
    case (state)
      S_IDLE: begin
        if (fs) begin
          load = 1'b1;
          din  = HEAD;
        end
      end
      S_HEAD: begin
        if (acc) begin
          load = 1'b1;
          din  = len_sh[LEN_W-1 -: 8];
        end
      end
      S_LEN: begin
        if (acc) begin
          if (idx != LEN_LAST) begin
            load = 1'b1;
            din  = len_nx[LEN_W-1 -: 8];
          end else if (len_q == '0) begin
            load = 1'b1;
            din  = fin_byte;
          end
        end
      end
      // Read strobe must coincide with RD so data lands in WAIT.
      S_RD: fifo_rxen = ~fifo_empty;
      S_WAIT: begin
        load = 1'b1;
        din  = fifo_rxd[DATA_W-1 -: 8];
      end
      S_BYTE: begin
        if (acc) begin
          if (idx != WORD_LAST) begin
            load = 1'b1;
            din  = word_nx[DATA_W-1 -: 8];
          end else if (last_word) begin
            load = 1'b1;
            din  = fin_byte;
          end
        end
      end
      S_CHK: begin
        if (acc) begin
          load = 1'b1;
          din  = TAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      len_q  <= '0;
      len_sh <= '0;
      wcnt   <= '0;
      word_q <= '0;
      idx    <= 8'h00;
      chk    <= 8'h00;
      fd     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      fd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fs) begin
            len_q  <= data_len;
            len_sh <= data_len;
            wcnt   <= '0;
            chk    <= 8'h00;
            idx    <= 8'h00;
            busy   <= 1'b1;
            state  <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (acc) begin
            idx   <= 8'h00;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (acc) begin
            chk <= sum_nx;
            if (idx != LEN_LAST) begin
              idx    <= idx + 8'd1;
              len_sh <= len_nx;
            end else if (len_q != '0) begin
              state <= S_RD;
            end else begin
              state <= CHK_EN ? S_CHK : S_TAIL;
            end
          end
        end
        S_RD: begin
          if (!fifo_empty) state <= S_WAIT;
        end
        S_WAIT: begin
          word_q <= fifo_rxd;
          idx    <= 8'h00;
          state  <= S_BYTE;
        end
        S_BYTE: begin
          if (acc) begin
            chk <= sum_nx;
            if (idx != WORD_LAST) begin
              idx    <= idx + 8'd1;
              word_q <= word_nx;
            end else begin
              wcnt <= wcnt_inc;
              if (last_word) state <= CHK_EN ? S_CHK : S_TAIL;
              else           state <= S_RD;
            end
          end
        end
        S_CHK: begin
          if (acc) state <= S_TAIL;
        end
        S_TAIL: begin
          if (acc) begin
            fd    <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2uart_framer.sv
// Directed bench: three framer instances (8-bit, 16-bit, no checksum)
// share a FIFO model and transmitter-ready source.
module tb_fifo2uart_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  fs = 3'b000;
  logic [7:0]  data_len = 8'h00;
  logic [15:0] fifo_rxd = 16'h0000;
  logic        fifo_empty;
  logic        txdr;
  logic        rnd = 1'b0;
  logic        rbit = 1'b1;
  logic        stall = 1'b0;
  logic        clr = 1'b0;

  logic [2:0]  fd, busy, rxen, txdv;
  logic [7:0]  txd [3];

  logic [15:0] fmem [256];
  int          fn = 0;
  int          rp = 0;
  logic        pend = 1'b0;
  int          sel = 0;

  logic [63:0] strm [3];
  int          nb [3];
  int          nfd [3];
  int          nrx [3];
  int          nviol [3];
  logic [2:0]  hold = 3'b000;
  logic [7:0]  htxd [3];

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  assign txdr       = rnd ? rbit : 1'b1;
  assign fifo_empty = stall || (rp >= fn);

  fifo2uart_framer #(.DATA_W(8), .LEN_W(8), .HEAD(8'hAA), .TAIL(8'h55), .CHK_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .fs(fs[0]), .data_len(data_len), .fd(fd[0]), .busy(busy[0]),
    .fifo_rxen(rxen[0]), .fifo_rxd(fifo_rxd[7:0]), .fifo_empty(fifo_empty),
    .uart_txd(txd[0]), .uart_txdv(txdv[0]), .uart_txdr(txdr));

  fifo2uart_framer #(.DATA_W(16), .LEN_W(8), .HEAD(8'hAA), .TAIL(8'h55), .CHK_EN(1'b1)) u_b (
    .clk(clk), .rst(rst), .fs(fs[1]), .data_len(data_len), .fd(fd[1]), .busy(busy[1]),
    .fifo_rxen(rxen[1]), .fifo_rxd(fifo_rxd), .fifo_empty(fifo_empty),
    .uart_txd(txd[1]), .uart_txdv(txdv[1]), .uart_txdr(txdr));

  fifo2uart_framer #(.DATA_W(8), .LEN_W(8), .HEAD(8'hAA), .TAIL(8'h55), .CHK_EN(1'b0)) u_c (
    .clk(clk), .rst(rst), .fs(fs[2]), .data_len(data_len), .fd(fd[2]), .busy(busy[2]),
    .fifo_rxen(rxen[2]), .fifo_rxd(fifo_rxd[7:0]), .fifo_empty(fifo_empty),
    .uart_txd(txd[2]), .uart_txdv(txdv[2]), .uart_txdr(txdr));

  always begin
    @(posedge clk);
    #1;
    rbit = 1'($urandom_range(0, 1));
  end

  // FIFO model: 1-cycle read latency, updated just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (clr) rp = 0;
    else if (pend) begin
      fifo_rxd = fmem[rp[7:0]];
      rp = rp + 1;
    end
  end

  always @(negedge clk) begin
    pend = rxen[sel[1:0]];
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        strm[i] = 64'h0; nb[i] = 0; nfd[i] = 0; nrx[i] = 0; nviol[i] = 0;
      end else begin
        if (txdv[i] && txdr) begin
          strm[i] = {strm[i][55:0], txd[i]};
          nb[i]++;
        end
        if (fd[i]) nfd[i]++;
        if (rxen[i]) nrx[i]++;
        if (hold[i] && (!txdv[i] || txd[i] != htxd[i])) nviol[i]++;
      end
      hold[i] = txdv[i] && !txdr && !rst;
      htxd[i] = txd[i];
    end
  end

  task automatic clear();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic start(input int s, input logic [7:0] len);
    sel = s;
    data_len = len;
    fs = 3'(1 << s);
    @(posedge clk);
    #1;
    fs = 3'b000;
  endtask

  task automatic wait_fd(input int s, input int budget);
    int t;
    t = 0;
    while (nfd[s] == 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (txdv !== 3'b000) $display("FAIL reset_txdv got %b want 000", txdv); else pass++;
    total++; if (busy !== 3'b000) $display("FAIL reset_busy got %b want 000", busy); else pass++;
    total++; if (fd !== 3'b000) $display("FAIL reset_fd got %b want 000", fd); else pass++;
    total++; if (rxen !== 3'b000) $display("FAIL reset_rxen got %b want 000", rxen); else pass++;
    rst = 1'b0;
    clear();
  endtask

  task automatic test_basic();
    clear();
    fmem[0] = 16'h11; fmem[1] = 16'h22; fmem[2] = 16'h33; fn = 3;
    start(0, 8'd3);
    @(negedge clk);
    total++; if ({txdv[0], txd[0]} !== 9'h1AA)
      $display("FAIL basic_head_latency got %b/%h want 1/aa", txdv[0], txd[0]); else pass++;
    total++; if (busy[0] !== 1'b1) $display("FAIL basic_busy got %b want 1", busy[0]); else pass++;
    @(posedge clk);
    #1;
    wait_fd(0, 200);
    total++; if (nb[0] !== 7) $display("FAIL basic_nbytes got %0d want 7", nb[0]); else pass++;
    total++; if (strm[0][55:0] !== 56'hAA031122336955)
      $display("FAIL basic_stream got %h want aa031122336955", strm[0][55:0]); else pass++;
    total++; if (nrx[0] !== 3) $display("FAIL basic_rxen got %0d want 3", nrx[0]); else pass++;
    total++; if (nfd[0] !== 1) $display("FAIL basic_fd got %0d want 1", nfd[0]); else pass++;
    total++; if (busy[0] !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy[0]); else pass++;
  endtask

  task automatic test_wide();
    clear();
    fmem[0] = 16'h1234; fmem[1] = 16'hABCD; fn = 2;
    start(1, 8'd2);
    wait_fd(1, 200);
    total++; if (nb[1] !== 8) $display("FAIL wide_nbytes got %0d want 8", nb[1]); else pass++;
    total++; if (strm[1] !== 64'hAA021234ABCDC055)
      $display("FAIL wide_stream got %h want aa021234abcdc055", strm[1]); else pass++;
    total++; if (nrx[1] !== 2) $display("FAIL wide_rxen got %0d want 2", nrx[1]); else pass++;
  endtask

  task automatic test_backpressure();
    clear();
    rnd = 1'b1;
    fmem[0] = 16'h11; fmem[1] = 16'h22; fmem[2] = 16'h33; fn = 3;
    start(0, 8'd3);
    repeat (6) @(posedge clk);
    #1;
    data_len = 8'h09;
    fs = 3'b001;
    @(posedge clk);
    #1;
    fs = 3'b000;
    wait_fd(0, 400);
    rnd = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (nb[0] !== 7) $display("FAIL bp_nbytes got %0d want 7", nb[0]); else pass++;
    total++; if (strm[0][55:0] !== 56'hAA031122336955)
      $display("FAIL bp_stream got %h want aa031122336955", strm[0][55:0]); else pass++;
    total++; if (nviol[0] !== 0) $display("FAIL bp_stable got %0d want 0", nviol[0]); else pass++;
    total++; if (nfd[0] !== 1) $display("FAIL bp_fd got %0d want 1", nfd[0]); else pass++;
    total++; if (nrx[0] !== 3) $display("FAIL bp_rxen got %0d want 3", nrx[0]); else pass++;
    total++; if (busy[0] !== 1'b0) $display("FAIL bp_busy got %b want 0", busy[0]); else pass++;
  endtask

  task automatic test_stall();
    int t;
    clear();
    fmem[0] = 16'h11; fmem[1] = 16'h22; fmem[2] = 16'h33; fn = 3;
    start(0, 8'd3);
    t = 0;
    while (nrx[0] < 1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    stall = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++; if (nrx[0] !== 1) $display("FAIL stall_rxen got %0d want 1", nrx[0]); else pass++;
    total++; if (busy[0] !== 1'b1) $display("FAIL stall_busy got %b want 1", busy[0]); else pass++;
    total++; if (txdv[0] !== 1'b0) $display("FAIL stall_txdv got %b want 0", txdv[0]); else pass++;
    stall = 1'b0;
    wait_fd(0, 200);
    total++; if (strm[0][55:0] !== 56'hAA031122336955)
      $display("FAIL stall_stream got %h want aa031122336955", strm[0][55:0]); else pass++;
    total++; if (nrx[0] !== 3) $display("FAIL stall_rxen_end got %0d want 3", nrx[0]); else pass++;
  endtask

  task automatic test_zero_len();
    clear();
    fn = 0;
    start(0, 8'd0);
    wait_fd(0, 100);
    total++; if (nb[0] !== 4) $display("FAIL zero_nbytes got %0d want 4", nb[0]); else pass++;
    total++; if (strm[0][31:0] !== 32'hAA000055)
      $display("FAIL zero_stream got %h want aa000055", strm[0][31:0]); else pass++;
    total++; if (nrx[0] !== 0) $display("FAIL zero_rxen got %0d want 0", nrx[0]); else pass++;
    total++; if (nfd[0] !== 1) $display("FAIL zero_fd got %0d want 1", nfd[0]); else pass++;
    clear();
    start(2, 8'd0);
    wait_fd(2, 100);
    total++; if (nb[2] !== 3) $display("FAIL nochk_zero_nbytes got %0d want 3", nb[2]); else pass++;
    total++; if (strm[2][23:0] !== 24'hAA0055)
      $display("FAIL nochk_zero_stream got %h want aa0055", strm[2][23:0]); else pass++;
    clear();
    fmem[0] = 16'h11; fmem[1] = 16'h22; fn = 2;
    start(2, 8'd2);
    wait_fd(2, 100);
    total++; if (strm[2][39:0] !== 40'hAA02112255)
      $display("FAIL nochk_stream got %h want aa02112255", strm[2][39:0]); else pass++;
    total++; if (nb[2] !== 5) $display("FAIL nochk_nbytes got %0d want 5", nb[2]); else pass++;
  endtask

  task automatic test_max_len();
    clear();
    for (int i = 0; i < 255; i++) fmem[i] = 16'(i);
    fn = 255;
    start(0, 8'd255);
    wait_fd(0, 2000);
    total++; if (nb[0] !== 259) $display("FAIL max_nbytes got %0d want 259", nb[0]); else pass++;
    total++; if (nrx[0] !== 255) $display("FAIL max_rxen got %0d want 255", nrx[0]); else pass++;
    total++; if (strm[0][39:0] !== 40'hFCFDFE8055)
      $display("FAIL max_tail got %h want fcfdfe8055", strm[0][39:0]); else pass++;
    total++; if (nfd[0] !== 1) $display("FAIL max_fd got %0d want 1", nfd[0]); else pass++;
  endtask

  task automatic test_rst_mid();
    int t;
    clear();
    fmem[0] = 16'h11; fmem[1] = 16'h22; fmem[2] = 16'h33; fn = 3;
    start(0, 8'd3);
    t = 0;
    while (nrx[0] < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (txdv[0] !== 1'b0) $display("FAIL rstmid_txdv got %b want 0", txdv[0]); else pass++;
    total++; if (busy[0] !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy[0]); else pass++;
    total++; if (fd[0] !== 1'b0) $display("FAIL rstmid_fd got %b want 0", fd[0]); else pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (nfd[0] !== 0) $display("FAIL rstmid_nofd got %0d want 0", nfd[0]); else pass++;
    total++; if (nrx[0] !== 2) $display("FAIL rstmid_norx got %0d want 2", nrx[0]); else pass++;
    clear();
    fmem[0] = 16'h44; fmem[1] = 16'h55; fmem[2] = 16'h66; fn = 3;
    start(0, 8'd3);
    wait_fd(0, 200);
    total++; if (strm[0][55:0] !== 56'hAA034455660255)
      $display("FAIL rstmid_fresh got %h want aa034455660255", strm[0][55:0]); else pass++;
    total++; if (nb[0] !== 7) $display("FAIL rstmid_nbytes got %0d want 7", nb[0]); else pass++;
    total++; if (nfd[0] !== 1) $display("FAIL rstmid_fd_end got %0d want 1", nfd[0]); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_backpressure();
    test_stall();
    test_zero_len();
    test_max_len();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
